// File: rtl/rect_draw_arbiter.sv
// rect_draw_arbiter
//
// Shares one rectangle-scan pixel engine between N drawing requesters. A
// round-robin arbiter picks a requester, its rectangle is latched, every pixel
// is scanned row by row (one pixel write per cycle), and the requester then
// receives a one-cycle acknowledge.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   req         per-requester draw request (level, held until ack)
//   req_x/y     flattened start coordinates, requester i at [10i+9:10i] / [9i+8:9i]
//   req_w/h     flattened rectangle width / height in pixels
//   req_colour  flattened fill colour
//   out_x/y     registered pixel coordinate to the VGA adapter
//   out_colour  registered pixel colour
//   plot        write enable for the current pixel
//   busy        high whenever the engine is not idle
//   grant_id    index of the current / last granted requester
//   ack         one-hot completion pulse

module rect_draw_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned COLOUR_W = 3,
  localparam int unsigned GW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N-1:0]            req,
  input  logic [N*10-1:0]         req_x,
  input  logic [N*9-1:0]          req_y,
  input  logic [N*10-1:0]         req_w,
  input  logic [N*9-1:0]          req_h,
  input  logic [N*COLOUR_W-1:0]   req_colour,
  output logic [9:0]              out_x,
  output logic [8:0]              out_y,
  output logic [COLOUR_W-1:0]     out_colour,
  output logic                    plot,
  output logic                    busy,
  output logic [GW-1:0]           grant_id,
  output logic [N-1:0]            ack
);

  typedef enum logic [1:0] {StIdle, StLatch, StDraw, StAck} state_e;

  state_e state_q, state_d;

  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [9:0]          lx_q, lx_d;
  logic [8:0]          ly_q, ly_d;
  logic [9:0]          lw_q, lw_d;
  logic [8:0]          lh_q, lh_d;
  logic [COLOUR_W-1:0] lc_q, lc_d;
  logic [9:0]          dx_q, dx_d;
  logic [8:0]          dy_q, dy_d;
  logic [9:0]          ox_q, ox_d;
  logic [8:0]          oy_q, oy_d;
  logic [COLOUR_W-1:0] oc_q, oc_d;
  logic                plot_q, plot_d;
  logic [N-1:0]        ack_q, ack_d;

  // Fields of the currently granted requester, straight from the inputs.
  logic [9:0]          sel_x;
  logic [8:0]          sel_y;
  logic [9:0]          sel_w;
  logic [8:0]          sel_h;
  logic [COLOUR_W-1:0] sel_c;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_w = '0;
    sel_h = '0;
    sel_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_q == GW'(i)) begin
        sel_x = req_x[i*10 +: 10];
        sel_y = req_y[i*9 +: 9];
        sel_w = req_w[i*10 +: 10];
        sel_h = req_h[i*9 +: 9];
        sel_c = req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // Round-robin search: first set request strictly after the pointer, wrapping.
  logic          rr_found;
  logic [GW-1:0] rr_winner;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!rr_found && req[i] && (((int'(ptr_q) + k) % int'(N)) == i)) begin
          rr_found  = 1'b1;
          rr_winner = GW'(i);
        end
      end
    end
  end

  // Scan stepping: dx is the inner loop, dy the outer loop.
  logic       row_end;
  logic       last_px;
  logic [9:0] nxt_dx;
  logic [8:0] nxt_dy;

  assign row_end = (dx_q == lw_q - 10'd1);
  assign last_px = row_end && (dy_q == lh_q - 9'd1);
  assign nxt_dx  = row_end ? 10'd0 : dx_q + 10'd1;
  assign nxt_dy  = row_end ? dy_q + 9'd1 : dy_q;

  // Untruncated pixel coordinates: the first pixel comes from the live
  // inputs (the latch happens on the same edge), the rest from latched state.
  logic [10:0] first_x, next_x;
  logic [9:0]  first_y, next_y;

  assign first_x = {1'b0, sel_x};
  assign first_y = {1'b0, sel_y};
  assign next_x  = {1'b0, lx_q} + {1'b0, nxt_dx};
  assign next_y  = {1'b0, ly_q} + {1'b0, nxt_dy};

  logic first_on_screen, next_on_screen;

  assign first_on_screen = (32'(first_x) < H_RES) && (32'(first_y) < V_RES);
  assign next_on_screen  = (32'(next_x) < H_RES) && (32'(next_y) < V_RES);

  logic [N-1:0] grant_onehot;
  assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    lw_d    = lw_q;
    lh_d    = lh_q;
    lc_d    = lc_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oc_d    = oc_q;
    plot_d  = 1'b0;
    ack_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_winner;
          ptr_d   = rr_winner;
          state_d = StLatch;
        end
      end

      StLatch: begin
        lx_d = sel_x;
        ly_d = sel_y;
        lw_d = sel_w;
        lh_d = sel_h;
        lc_d = sel_c;
        dx_d = '0;
        dy_d = '0;
        if (sel_w == '0 || sel_h == '0) begin
          ack_d   = grant_onehot;
          state_d = StAck;
        end else begin
          // Present pixel (0,0) on the edge that enters the draw state.
          ox_d    = first_x[9:0];
          oy_d    = first_y[8:0];
          oc_d    = sel_c;
          plot_d  = first_on_screen;
          state_d = StDraw;
        end
      end

      StDraw: begin
        if (last_px) begin
          ack_d   = grant_onehot;
          state_d = StAck;
        end else begin
          dx_d   = nxt_dx;
          dy_d   = nxt_dy;
          ox_d   = next_x[9:0];
          oy_d   = next_y[8:0];
          oc_d   = lc_q;
          plot_d = next_on_screen;
        end
      end

      StAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ptr_q   <= GW'(N - 1);
      grant_q <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      lw_q    <= '0;
      lh_q    <= '0;
      lc_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oc_q    <= '0;
      plot_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      lw_q    <= lw_d;
      lh_q    <= lh_d;
      lc_q    <= lc_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oc_q    <= oc_d;
      plot_q  <= plot_d;
      ack_q   <= ack_d;
    end
  end

  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign out_colour = oc_q;
  assign plot       = plot_q;
  assign ack        = ack_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Testbench for rect_draw_arbiter. A driver issues rectangle requests and
// pushes the expected pixel writes and acks (with their cycle numbers) into a
// scoreboard queue; an independent monitor pops and compares whenever the DUT
// plots or acks.

module tb_rect_draw_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_v = 4'b0;
  logic [9:0]  fx [4];
  logic [8:0]  fy [4];
  logic [9:0]  fw [4];
  logic [8:0]  fh [4];
  logic [2:0]  fc [4];

  logic [39:0] req_x;
  logic [35:0] req_y;
  logic [39:0] req_w;
  logic [35:0] req_h;
  logic [11:0] req_colour;

  assign req_x      = {fx[3], fx[2], fx[1], fx[0]};
  assign req_y      = {fy[3], fy[2], fy[1], fy[0]};
  assign req_w      = {fw[3], fw[2], fw[1], fw[0]};
  assign req_h      = {fh[3], fh[2], fh[1], fh[0]};
  assign req_colour = {fc[3], fc[2], fc[1], fc[0]};

  logic [9:0] out_x;
  logic [8:0] out_y;
  logic [2:0] out_colour;
  logic       plot;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] ack;

  rect_draw_arbiter #(
    .N       (4),
    .H_RES   (640),
    .V_RES   (480),
    .COLOUR_W(3)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req_v),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_w     (req_w),
    .req_h     (req_h),
    .req_colour(req_colour),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_colour(out_colour),
    .plot      (plot),
    .busy      (busy),
    .grant_id  (grant_id),
    .ack       (ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_ack;
    int x;
    int y;
    int c;
    int id;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ptr_m = N - 1;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Round robin: first requester after the last winner, wrapping.
  function automatic int rr_pick(input int ptr, input logic [3:0] m);
    int unsigned i;
    logic [1:0] ii;
    for (int k = 1; k <= N; k++) begin
      i  = (ptr + k) % N;
      ii = i[1:0];
      if (m[ii]) return int'(ii);
    end
    return -1;
  endfunction

  // Expected pixels of one rectangle granted while idle in cycle g.
  task automatic push_rect(input int id, input int g, output int ackc);
    logic [1:0] k;
    int x, y, w, h, c;
    exp_t e;
    k = id[1:0];
    x = int'(fx[k]);
    y = int'(fy[k]);
    w = int'(fw[k]);
    h = int'(fh[k]);
    c = int'(fc[k]);
    if (w == 0 || h == 0) begin
      w = 0;
      h = 0;
    end
    for (int dy = 0; dy < h; dy++) begin
      for (int dx = 0; dx < w; dx++) begin
        if (x + dx < 640 && y + dy < 480) begin
          e = '{is_ack: 1'b0, x: x + dx, y: y + dy, c: c, id: id, cyc: g + 2 + dy * w + dx};
          exp_q.push_back(e);
        end
      end
    end
    ackc = g + 2 + w * h;
    e = '{is_ack: 1'b1, x: 0, y: 0, c: 0, id: id, cyc: ackc};
    exp_q.push_back(e);
  endtask

  // Raise the masked requests together; each drops its request in its ack cycle.
  task automatic run_batch(input logic [3:0] mask, input bit tamper, output int last_ack);
    logic [3:0] m;
    int g, g0, win, ackc, id;
    int drop_id[$];
    int drop_cyc[$];
    @(negedge clock);
    req_v = req_v | mask;
    g  = cyc;
    g0 = g;
    m  = mask;
    while (m != 4'b0) begin
      win   = rr_pick(ptr_m, m);
      ptr_m = win;
      push_rect(win, g, ackc);
      drop_id.push_back(win);
      drop_cyc.push_back(ackc);
      m[win[1:0]] = 1'b0;
      g = ackc + 1;
    end
    if (tamper) begin
      while (cyc < g0 + 4) @(negedge clock);
      fx[0]    = fx[0] + 10'd7;
      req_v[0] = 1'b0;
    end
    last_ack = 0;
    for (int j = 0; j < drop_id.size(); j++) begin
      while (cyc < drop_cyc[j]) @(negedge clock);
      id = drop_id[j];
      req_v[id[1:0]] = 1'b0;
      last_ack = drop_cyc[j];
    end
  endtask

  exp_t mon_e;

  always @(negedge clock) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        chk(mon_e.is_ack ? "missed_ack_cycle" : "missed_plot_cycle", cyc, mon_e.cyc);
      end
      if (plot) begin
        if (exp_q.size() == 0 || exp_q[0].is_ack) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_x", int'(out_x), mon_e.x);
          chk("pix_y", int'(out_y), mon_e.y);
          chk("pix_colour", int'(out_colour), mon_e.c);
          chk("pix_cycle", cyc, mon_e.cyc);
        end
      end
      if (ack != 4'b0) begin
        if (exp_q.size() == 0 || !exp_q[0].is_ack) begin
          chk("unexpected_ack", int'(ack), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_vec", int'(ack), 1 << mon_e.id);
          chk("grant_id", int'(grant_id), mon_e.id);
          chk("ack_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    int a, g;
    logic [3:0] mask;
    for (int i = 0; i < N; i++) begin
      fx[i] = '0;
      fy[i] = '0;
      fw[i] = '0;
      fh[i] = '0;
      fc[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_colour", int'(out_colour), 0);
    chk("rst_grant", int'(grant_id), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Basic 3x2 rectangle
    fx[0] = 10'd10; fy[0] = 9'd20; fw[0] = 10'd3; fh[0] = 9'd2; fc[0] = 3'd5;
    run_batch(4'b0001, 1'b0, a);
    chk("t1_busy_in_ack", int'(busy), 1);
    @(negedge clock);
    chk("t1_busy_low", int'(busy), 0);

    // All four requesting 1x1 rectangles, two rounds
    for (int i = 0; i < N; i++) begin
      fx[i] = 10'(100 + 10 * i); fy[i] = 9'(40 + i); fw[i] = 10'd1; fh[i] = 9'd1;
      fc[i] = 3'(i + 1);
    end
    run_batch(4'b1111, 1'b0, a);
    run_batch(4'b1111, 1'b0, a);

    // Zero width
    fx[2] = 10'd5; fy[2] = 9'd5; fw[2] = 10'd0; fh[2] = 9'd5; fc[2] = 3'd3;
    run_batch(4'b0100, 1'b0, a);
    @(negedge clock);
    chk("t3_busy_low", int'(busy), 0);

    // Clipping at the bottom-right corner
    fx[1] = 10'd638; fy[1] = 9'd479; fw[1] = 10'd4; fh[1] = 9'd2; fc[1] = 3'd6;
    run_batch(4'b0010, 1'b0, a);

    // Fields changed and request dropped mid-scan
    fx[0] = 10'd100; fy[0] = 9'd50; fw[0] = 10'd5; fh[0] = 9'd3; fc[0] = 3'd2;
    run_batch(4'b0001, 1'b1, a);

    // Randomized batches
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        fx[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(620, 700))
                                             : 10'($urandom_range(0, 639));
        fy[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(470, 511))
                                             : 9'($urandom_range(0, 479));
        fw[i] = 10'($urandom_range(0, 5));
        fh[i] = 9'($urandom_range(0, 4));
        fc[i] = 3'($urandom_range(0, 7));
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_batch(mask, 1'b0, a);
    end

    // Asynchronous reset in the middle of a scan
    @(negedge clock);
    mon_en = 1'b0;
    fx[2] = 10'd20; fy[2] = 9'd30; fw[2] = 10'd8; fh[2] = 9'd4; fc[2] = 3'd6;
    @(negedge clock);
    req_v = 4'b0100;
    g = cyc;
    while (cyc < g + 5) @(negedge clock);
    chk("t6_plot_before", int'(plot), 1);
    chk("t6_busy_before", int'(busy), 1);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("t6_plot_rst", int'(plot), 0);
    chk("t6_busy_rst", int'(busy), 0);
    chk("t6_ack_rst", int'(ack), 0);
    req_v = 4'b0;
    exp_q.delete();
    ptr_m = N - 1;
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1'b1;
    fx[1] = 10'd200; fy[1] = 9'd100; fw[1] = 10'd2; fh[1] = 9'd2; fc[1] = 3'd1;
    fx[3] = 10'd300; fy[3] = 9'd200; fw[3] = 10'd1; fh[3] = 9'd3; fc[3] = 3'd7;
    run_batch(4'b1010, 1'b0, a);

    // Drain the scoreboard
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
